// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and watchdog constants for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    localparam int WDOG_W       = 6;
    localparam int WDOG_MAX_DEF = 63;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - arbiter to mem_system bus
interface mem_arbiter_if;

    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [15:0] rdata;
    logic        done;
    logic        hit;
    logic        err;

    modport master (
        output addr, wdata, rd, wr,
        input  rdata, done, hit, err
    );

    modport slave (
        input  addr, wdata, rd, wr,
        output rdata, done, hit, err
    );

endinterface

// File: rtl/sat_cntr.sv
// rtl/sat_cntr.sv - saturating up counter with asynchronous active-low reset
module sat_cntr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data port arbiter in front of mem_system
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WDOG_MAX = WDOG_MAX_DEF,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_rd,
    input  logic [15:0]        i_addr,
    output logic [15:0]        i_data,
    output logic               i_done,
    output logic               i_stall,
    input  logic               d_rd,
    input  logic               d_wr,
    input  logic [15:0]        d_addr,
    input  logic [15:0]        d_wdata,
    output logic [15:0]        d_rdata,
    output logic               d_done,
    output logic               d_stall,
    mem_arbiter_if.master      mem,
    output logic               err,
    output logic [CNT_W-1:0]   i_acc,
    output logic [CNT_W-1:0]   i_hits,
    output logic [CNT_W-1:0]   d_acc,
    output logic [CNT_W-1:0]   d_hits
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              i_starved;
    logic              illegal_q;
    logic [WDOG_W-1:0] wdog;

    logic i_req;
    logic d_req;
    logic d_illegal;
    logic grant_i;
    logic grant_d;
    logic done_mem;
    logic wdog_hit;
    logic fin;
    logic timeout;
    logic i_acc_inc;
    logic i_hit_inc;
    logic d_acc_inc;
    logic d_hit_inc;

    assign i_req     = i_rd;
    assign d_req     = d_rd | d_wr;
    assign d_illegal = d_rd & d_wr;

    // D wins by default; a starved I wins the next contention
    always_comb begin
        grant_d = d_req & ~(i_req & i_starved);
        grant_i = i_req & ~grant_d;
    end

    // end-of-transaction sources while busy: real completion, watchdog, or illegal op
    always_comb begin
        done_mem = mem.done & ~illegal_q;
        wdog_hit = (wdog == WDOG_W'(WDOG_MAX - 1));
        fin      = (state != IDLE) & (illegal_q | done_mem | wdog_hit);
        timeout  = (state != IDLE) & wdog_hit & ~done_mem & ~illegal_q;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (fin) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: issue in IDLE, route completion back while busy; all quiet in reset
    always_comb begin
        mem.addr  = '0;
        mem.wdata = '0;
        mem.rd    = 1'b0;
        mem.wr    = 1'b0;
        i_done    = 1'b0;
        i_data    = '0;
        d_done    = 1'b0;
        d_rdata   = '0;
        i_acc_inc = 1'b0;
        i_hit_inc = 1'b0;
        d_acc_inc = 1'b0;
        d_hit_inc = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem.addr  = d_addr;
                        mem.wdata = d_wdata;
                        mem.rd    = d_rd & ~d_wr;
                        mem.wr    = d_wr & ~d_rd;
                    end else if (grant_i) begin
                        mem.addr = i_addr;
                        mem.rd   = 1'b1;
                    end
                end
                BUSY_I: begin
                    i_done    = fin;
                    i_data    = done_mem ? mem.rdata : 16'h0000;
                    i_acc_inc = done_mem;
                    i_hit_inc = done_mem & mem.hit;
                end
                BUSY_D: begin
                    d_done    = fin;
                    d_rdata   = done_mem ? mem.rdata : 16'h0000;
                    d_acc_inc = done_mem;
                    d_hit_inc = done_mem & mem.hit;
                end
                default: ;
            endcase
        end
    end

    assign i_stall = i_rd & ~i_done;
    assign d_stall = d_req & ~d_done;

    // fairness flag, watchdog and illegal-op marker, all re-evaluated at issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_starved <= 1'b0;
            illegal_q <= 1'b0;
            wdog      <= '0;
        end else if (state == IDLE) begin
            wdog      <= '0;
            illegal_q <= grant_d & d_illegal;
            if (grant_i) begin
                i_starved <= 1'b0;
            end else if (grant_d & i_req) begin
                i_starved <= 1'b1;
            end
        end else begin
            wdog <= wdog + WDOG_W'(1);
        end
    end

    // sticky error: memory error, illegal data op, or watchdog abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (mem.err || timeout || ((state == IDLE) && grant_d && d_illegal)) begin
            err <= 1'b1;
        end
    end

    sat_cntr #(.W(CNT_W)) u_i_acc  (.clk(clk), .rst_n(rst_n), .inc(i_acc_inc), .count(i_acc));
    sat_cntr #(.W(CNT_W)) u_i_hits (.clk(clk), .rst_n(rst_n), .inc(i_hit_inc), .count(i_hits));
    sat_cntr #(.W(CNT_W)) u_d_acc  (.clk(clk), .rst_n(rst_n), .inc(d_acc_inc), .count(d_acc));
    sat_cntr #(.W(CNT_W)) u_d_hits (.clk(clk), .rst_n(rst_n), .inc(d_hit_inc), .count(d_hits));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_rd, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        m_done, m_hit, m_err;

    logic [15:0] i_data, d_rdata, i_data2, d_rdata2;
    logic        i_done, i_stall, d_done, d_stall, err;
    logic        i_done2, i_stall2, d_done2, d_stall2, err2;
    logic [15:0] i_acc, i_hits, d_acc, d_hits;
    logic [1:0]  i_acc2, i_hits2, d_acc2, d_hits2;

    int errors = 0;
    int checks = 0;
    int bad;

    mem_arbiter_if mif ();
    mem_arbiter_if mif2 ();

    assign mif.rdata  = m_rdata;
    assign mif.done   = m_done;
    assign mif.hit    = m_hit;
    assign mif.err    = m_err;
    assign mif2.rdata = m_rdata;
    assign mif2.done  = m_done;
    assign mif2.hit   = m_hit;
    assign mif2.err   = m_err;

    mem_arbiter #(.WDOG_MAX(63), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data),
        .i_done(i_done), .i_stall(i_stall), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem(mif), .err(err), .i_acc(i_acc), .i_hits(i_hits), .d_acc(d_acc), .d_hits(d_hits)
    );

    mem_arbiter #(.WDOG_MAX(63), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data2),
        .i_done(i_done2), .i_stall(i_stall2), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata2), .d_done(d_done2), .d_stall(d_stall2),
        .mem(mif2), .err(err2), .i_acc(i_acc2), .i_hits(i_hits2), .d_acc(d_acc2), .d_hits(d_hits2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rd = 0; d_rd = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        m_rdata = 0; m_done = 0; m_hit = 0; m_err = 0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        step();
        i_rd = 1; d_rd = 1; i_addr = 16'h0044; d_addr = 16'h0088;
        #1;
        checks++; if (mif.rd !== 1'b0) begin errors++; $display("FAIL reset_m_rd got=%h exp=0", mif.rd); end
        checks++; if (mif.addr !== 16'h0000) begin errors++; $display("FAIL reset_m_addr got=%h exp=0000", mif.addr); end
        checks++; if (i_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b%b exp=11", i_stall, d_stall); end
        checks++; if (i_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b%b exp=000", i_done, d_done, err); end
        checks++; if (i_acc !== 16'd0 || d_hits !== 16'd0 || dut.state !== 2'b00) begin errors++; $display("FAIL reset_cnt_state got=%h %h %h exp=0 0 0", i_acc, d_hits, dut.state); end
        idle_inputs();
        step();
        rst_n = 1;
    endtask

    task automatic test_fetch_hit();
        step();
        i_rd = 1; i_addr = 16'h0010;
        #1;
        checks++; if (mif.rd !== 1'b1 || mif.addr !== 16'h0010) begin errors++; $display("FAIL fetch_issue got rd=%h addr=%h exp rd=1 addr=0010", mif.rd, mif.addr); end
        step();
        m_done = 1; m_hit = 1; m_rdata = 16'hBEEF;
        #1;
        checks++; if (mif.rd !== 1'b0) begin errors++; $display("FAIL fetch_m_rd_busy got=%h exp=0", mif.rd); end
        checks++; if (i_done !== 1'b1 || i_data !== 16'hBEEF) begin errors++; $display("FAIL fetch_done got done=%h data=%h exp done=1 data=beef", i_done, i_data); end
        checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall got=%h exp=0", i_stall); end
        step();
        i_rd = 0; m_done = 0; m_hit = 0; m_rdata = 0;
        #1;
        checks++; if (i_done !== 1'b0 || i_data !== 16'h0000) begin errors++; $display("FAIL fetch_after got done=%h data=%h exp 0 0000", i_done, i_data); end
        checks++; if (i_acc !== 16'd1 || i_hits !== 16'd1) begin errors++; $display("FAIL fetch_cnt got acc=%0d hits=%0d exp 1 1", i_acc, i_hits); end
    endtask

    task automatic test_contention();
        step();
        i_rd = 1; d_rd = 1; i_addr = 16'h0100; d_addr = 16'h0200;
        #1;
        checks++; if (mif.addr !== 16'h0200 || mif.rd !== 1'b1) begin errors++; $display("FAIL cont_g1 got addr=%h exp=0200", mif.addr); end
        step();
        m_done = 1; m_hit = 1; m_rdata = 16'h1111;
        #1;
        checks++; if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 16'h1111) begin errors++; $display("FAIL cont_d1 got d=%h i=%h data=%h exp 1 0 1111", d_done, i_done, d_rdata); end
        checks++; if (dut.i_starved !== 1'b1) begin errors++; $display("FAIL cont_starved_set got=%h exp=1", dut.i_starved); end
        step();
        m_done = 0;
        #1;
        checks++; if (mif.addr !== 16'h0100 || mif.rd !== 1'b1) begin errors++; $display("FAIL cont_g2 got addr=%h exp=0100", mif.addr); end
        step();
        m_done = 1; m_rdata = 16'h2222;
        #1;
        checks++; if (i_done !== 1'b1 || d_done !== 1'b0 || i_data !== 16'h2222) begin errors++; $display("FAIL cont_i2 got i=%h d=%h data=%h exp 1 0 2222", i_done, d_done, i_data); end
        checks++; if (dut.i_starved !== 1'b0) begin errors++; $display("FAIL cont_starved_clr got=%h exp=0", dut.i_starved); end
        step();
        m_done = 0;
        #1;
        checks++; if (mif.addr !== 16'h0200) begin errors++; $display("FAIL cont_g3 got addr=%h exp=0200", mif.addr); end
        step();
        m_done = 1; m_rdata = 16'h3333;
        #1;
        checks++; if (d_done !== 1'b1 || d_rdata !== 16'h3333) begin errors++; $display("FAIL cont_d3 got d=%h data=%h exp 1 3333", d_done, d_rdata); end
        step();
        idle_inputs();
        #1;
        checks++; if (d_acc !== 16'd2 || i_acc !== 16'd2 || i_hits !== 16'd2) begin errors++; $display("FAIL cont_cnt got dacc=%0d iacc=%0d ihits=%0d exp 2 2 2", d_acc, i_acc, i_hits); end
    endtask

    task automatic test_write_miss();
        step();
        d_wr = 1; d_addr = 16'h1234; d_wdata = 16'h5A5A;
        #1;
        checks++; if (mif.wr !== 1'b1 || mif.rd !== 1'b0 || mif.wdata !== 16'h5A5A || mif.addr !== 16'h1234) begin errors++; $display("FAIL wmiss_issue got wr=%h rd=%h wd=%h a=%h", mif.wr, mif.rd, mif.wdata, mif.addr); end
        bad = 0;
        for (int k = 1; k < 12; k++) begin
            step();
            #1;
            if (mif.wr !== 1'b0 || d_done !== 1'b0 || d_stall !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wmiss_wait got bad_cycles=%0d exp=0", bad); end
        step();
        m_done = 1; m_hit = 0;
        #1;
        checks++; if (d_done !== 1'b1) begin errors++; $display("FAIL wmiss_done got=%h exp=1", d_done); end
        step();
        idle_inputs();
        #1;
        checks++; if (d_acc !== 16'd3 || d_hits !== 16'd2) begin errors++; $display("FAIL wmiss_cnt got acc=%0d hits=%0d exp 3 2", d_acc, d_hits); end
    endtask

    task automatic test_watchdog();
        step();
        i_rd = 1; i_addr = 16'h0ABC;
        bad = 0;
        for (int k = 1; k < 63; k++) begin
            step();
            #1;
            if (i_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wdog_early got bad_cycles=%0d exp=0", bad); end
        step();
        #1;
        checks++; if (i_done !== 1'b1 || i_data !== 16'h0000) begin errors++; $display("FAIL wdog_done got done=%h data=%h exp 1 0000", i_done, i_data); end
        step();
        i_rd = 0;
        #1;
        checks++; if (err !== 1'b1 || dut.state !== 2'b00) begin errors++; $display("FAIL wdog_after got err=%h state=%h exp 1 0", err, dut.state); end
        checks++; if (i_acc !== 16'd2) begin errors++; $display("FAIL wdog_cnt got=%0d exp=2", i_acc); end
    endtask

    task automatic test_illegal();
        do_reset();
        step();
        d_rd = 1; d_wr = 1; d_addr = 16'h0F0F;
        #1;
        checks++; if (mif.rd !== 1'b0 || mif.wr !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL ill_issue got rd=%h wr=%h done=%h exp 0 0 0", mif.rd, mif.wr, d_done); end
        step();
        #1;
        checks++; if (d_done !== 1'b1 || err !== 1'b1 || d_rdata !== 16'h0000) begin errors++; $display("FAIL ill_done got done=%h err=%h data=%h exp 1 1 0000", d_done, err, d_rdata); end
        step();
        idle_inputs();
        #1;
        checks++; if (d_acc !== 16'd0 || d_hits !== 16'd0) begin errors++; $display("FAIL ill_cnt got acc=%0d hits=%0d exp 0 0", d_acc, d_hits); end
    endtask

    task automatic test_m_err();
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL merr_clear got=%h exp=0", err); end
        step();
        m_err = 1;
        step();
        m_err = 0;
        step(); step();
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL merr_sticky got=%h exp=1", err); end
        rst_n = 0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL merr_rst got=%h exp=0", err); end
        step();
        rst_n = 1;
    endtask

    task automatic test_reset_mid_miss();
        step();
        d_rd = 1; d_addr = 16'h4444;
        step(); step();
        #1;
        checks++; if (dut.state !== 2'b10) begin errors++; $display("FAIL midrst_busy got=%h exp=2", dut.state); end
        rst_n = 0;
        #1;
        checks++; if (dut.state !== 2'b00 || d_done !== 1'b0 || mif.rd !== 1'b0 || mif.addr !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL midrst_out got st=%h done=%h rd=%h a=%h", dut.state, d_done, mif.rd, mif.addr); end
        checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL midrst_stall got=%h exp=1", d_stall); end
        idle_inputs();
        step();
        rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        step();
        i_rd = 1; i_addr = 16'h0020;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            m_done = 0; m_hit = 0;
            #1;
            if (mif.rd !== 1'b1) bad++;
            step();
            m_done = 1; m_hit = 1; m_rdata = 16'h0100 + 16'(k);
            #1;
            if (i_done !== 1'b1 || i_done2 !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_b2b got bad=%0d exp=0", bad); end
        idle_inputs();
        #1;
        checks++; if (i_hits2 !== 2'd3 || i_acc2 !== 2'd3) begin errors++; $display("FAIL sat_hold got hits=%0d acc=%0d exp 3 3", i_hits2, i_acc2); end
        checks++; if (i_hits !== 16'd4) begin errors++; $display("FAIL sat_wide got=%0d exp=4", i_hits); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_hit();
        test_contention();
        test_write_miss();
        test_watchdog();
        test_illegal();
        test_m_err();
        test_reset_mid_miss();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one `mem_system` (two-way set-associative cache plus four-bank memory) between the instruction-fetch port and the data-memory port of the processor. Grants one outstanding request at a time, drives the cache's `Addr/DataIn/Rd/Wr`, and routes `Done/DataOut/CacheHit` back to the granted port. It also runs a per-request watchdog, a sticky error flag, and per-port hit/access counters.

## Interface
- `WDOG_MAX`, 63: busy cycles without `Done` before abort.
- `CNT_W`, 16: width of the performance counters.
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous active-low reset`
- `i_rd  in  1  fetch request, held until i_done`
- `i_addr  in  16  fetch address`
- `i_data  out  16  fetch data, valid with i_done`
- `i_done  out  1  one-cycle completion pulse`
- `i_stall  out  1  = i_rd & ~i_done`
- `d_rd, d_wr  in  1 each  data request, held until d_done`
- `d_addr, d_wdata  in  16 each  data address / write data`
- `d_rdata  out  16  read data, valid with d_done`
- `d_done  out  1  one-cycle completion pulse`
- `d_stall  out  1  = (d_rd|d_wr) & ~d_done`
- `m_addr, m_wdata  out  16 each  to mem_system Addr/DataIn`
- `m_rd, m_wr  out  1 each  to mem_system Rd/Wr`
- `m_rdata  in  16  mem_system DataOut`
- `m_done, m_hit, m_err  in  1 each  mem_system Done/CacheHit/err`
- `err  out  1  sticky error`
- `i_acc, i_hits, d_acc, d_hits  out  CNT_W each  saturating counters`

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: choose a winner among pending requests; drive `m_addr/m_wdata/m_rd/m_wr` from it combinationally in that same cycle (mem_system samples `Addr`/`DataIn` in its own idle cycle); next state BUSY_I or BUSY_D. Outside this issue cycle, `m_rd = m_wr = 0`.
- Arbitration: data port wins by default. A 1-bit `i_starved` flag is set when both ports request and D wins; while set, I wins the next contention. The flag clears on any I grant.
- BUSY_x: `m_rd/m_wr` are low. On `m_done`:
  - pulse `x_done`;
  - route `m_rdata` to `x_data`/`d_rdata`;
  - increment `x_acc`, and `x_hits` if `m_hit`;
  - return to IDLE.
- Outside their done pulse, `i_data` and `d_rdata` are 0.
- `d_rd & d_wr` together is illegal: the data port is granted and no memory op is issued, `d_done` pulses the next cycle, `err` is set, and counters are unchanged.
- Watchdog: a 6-bit counter clears on issue and increments each BUSY cycle. When it reaches `WDOG_MAX`: pulse done to the granted port with data 0, set `err`, return to IDLE.
- `m_err` at any cycle sets `err`. `err` clears only on reset.
- Counters saturate at all-ones and never wrap.
- Done to a port is never pulsed unless that port holds a grant.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state → IDLE;
  - `i_starved`, watchdog, `err` and all counters → 0;
  - all `*_done`, `m_rd`, `m_wr`, `i_data`, `d_rdata`, `m_addr`, `m_wdata` → 0;
  - `i_stall`/`d_stall` follow their inputs combinationally.
- Cache hit: issue at cycle N, `m_done` at N+1, `x_done` at N+1. Request-to-done is 2 cycles including issue.
- Miss: `x_done` arrives in the same cycle as `m_done`.
- Back-to-back: the state returns to IDLE at N+2 and can issue again at N+2. A port's request that is still asserted in the cycle after its done is treated as a new request.
- Arbitration sees the requests present in the IDLE cycle only. Requests arriving during BUSY wait.

## Structure
- Shared package `mem_arb_pkg`: state encodings (IDLE = 2'b00, BUSY_I = 2'b01, BUSY_D = 2'b10), the watchdog counter width, and the default `WDOG_MAX`.
- One sub-module, `sat_cntr`: a `CNT_W`-bit saturating counter with `inc` and asynchronous active-low reset, instantiated four times.
- The state register, `i_starved`, and the watchdog live in `mem_arbiter`. The block does not instantiate `mem_system`; the top level connects them and drives `mem_system.rst = ~rst_n`.

## Test plan
- Fetch-only hit: `i_rd=1`, `i_addr=16'h0010`, model `m_done`/`m_hit` at N+1 with `m_rdata=16'hBEEF` → `m_rd` high only at N, `i_done` and `i_data=16'hBEEF` at N+1, `i_acc=i_hits=1`.
- Contention fairness: `i_rd` and `d_rd` held for three transactions → grant order D, I, D; `i_starved` set after the first grant and cleared after the second.
- Data write miss: `d_wr=1`, `d_addr=16'h1234`, `d_wdata=16'h5A5A`, `m_done` after 12 cycles with `m_hit=0` → `m_wr` high only at issue with `m_wdata=16'h5A5A`, `d_done` with `m_done`, `d_acc=1`, `d_hits=0`.
- Watchdog: grant to I, never assert `m_done` → at 63 BUSY cycles `i_done` pulses with `i_data=0`, `err=1`, state IDLE.
- Illegal plus error: `d_rd=d_wr=1` → no `m_rd`/`m_wr`, `d_done` the next cycle, `err=1`. Separately, a one-cycle `m_err` pulse → `err` stays 1 until `rst_n` is low.
- Reset mid-miss and saturation: assert `rst_n=0` during BUSY_D → all outputs 0 immediately, state IDLE. Run with `CNT_W=2` and four hits → `i_hits` holds at 3.
